reg_file_wb: RTL and testbench
==============================

REG_FILE_WB -- requirements
Module: reg_file_wb

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with the ports listed below.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 w_en  input  1  write enable from the write-address controller.
REQ-005 w_waddr_sel  input  1  write-address select: 1 selects w_rt, 0 selects w_rd; don't-care while w_en=0.
REQ-006 w_rt  input  5  rt field of the instruction being written back.
REQ-007 w_rd  input  5  rd field of the instruction being written back.
REQ-008 w_wdata  input  32  write-back data.
REQ-009 w_raddr_a  input  5  read port A address (rs).
REQ-010 w_raddr_b  input  5  read port B address (rt).
REQ-011 w_rdata_a  output  32  read port A data (combinational).
REQ-012 w_rdata_b  output  32  read port B data (combinational).
REQ-013 w_wb_valid  output  1  registered pulse: a write committed on the previous edge.
REQ-014 w_wb_addr  output  5  registered address of the last committed write.
REQ-015 w_wb_data  output  32  registered data of the last committed write.

Function
REQ-016 Storage SHALL be 32 x 32-bit registers, r0..r31.
REQ-017 Effective write address SHALL be w_rt when w_waddr_sel=1, and w_rd when w_waddr_sel=0.
REQ-018 A write SHALL commit on the rising clock edge when w_en=1 and the effective address is nonzero: reg[addr] <= w_wdata.
REQ-019 Writes to address 0 SHALL be discarded; r0 SHALL always read 32'h0.
REQ-020 When w_en=0, no register SHALL change, regardless of w_waddr_sel, w_rt, w_rd, or w_wdata (including X or Z values).
REQ-021 The read ports SHALL be combinational, with zero-cycle latency from address to data.
REQ-022 Write-through bypass SHALL apply: if w_en=1, the effective address is nonzero, and it equals w_raddr_a (or w_raddr_b), then that port SHALL return w_wdata in the same cycle.
REQ-023 Otherwise, each read port SHALL return the stored register value.
REQ-024 Both ports SHALL bypass independently when both read the write address.
REQ-025 Write-log update SHALL be: on each edge, w_wb_valid <= w_en & (eff_addr != 0).
REQ-026 When a write commits, w_wb_addr and w_wb_data SHALL load eff_addr and w_wdata; otherwise they SHALL hold their value.
REQ-027 w_wb_valid SHALL be high for exactly one cycle per committed write and SHALL stay high across back-to-back writes.
REQ-028 Write-commit latency SHALL be 1 edge; the new value is visible on a read port with no bypass from the cycle after the edge.

Reset
REQ-029 reset=1 SHALL asynchronously clear r0..r31 to 0, w_wb_valid to 0, w_wb_addr to 0, and w_wb_data to 0, without waiting for a clock edge.
REQ-030 During reset, writes SHALL be blocked and the bypass SHALL be disabled, so both read ports return 0.
REQ-031 On the first rising edge after reset deasserts, normal writes SHALL resume.
REQ-032 Reset asserted between edges SHALL clear all state immediately, and a pending write in that cycle SHALL be lost.

Verification
REQ-033 Reset/read: assert reset, then release it, then read all 32 addresses on both ports -> every read returns 32'h0 and w_wb_valid=0.
REQ-034 Select: w_en=1, w_waddr_sel=1, w_rt=5, w_rd=9, w_wdata=32'hDEADBEEF, one edge -> r5=32'hDEADBEEF, r9=0, w_wb_valid=1, w_wb_addr=5, w_wb_data=32'hDEADBEEF. Repeat with w_waddr_sel=0 and w_wdata=32'h12345678 -> r9=32'h12345678.
REQ-035 Bypass: w_en=1, w_waddr_sel=0, w_rd=7, w_wdata=32'hA5A5A5A5, w_raddr_a=7, w_raddr_b=7, with r7 previously 0 -> both ports show 32'hA5A5A5A5 before the edge, and r7 holds the value after the edge.
REQ-036 r0: w_en=1, effective address 0, w_wdata=32'hFFFFFFFF, one edge -> reads of r0 return 0, w_wb_valid=0, and w_wb_addr and w_wb_data are unchanged.
REQ-037 Disabled write: w_en=0, w_waddr_sel=X, w_rt=3, w_wdata=32'h1, several edges -> r3 is unchanged and w_wb_valid=0.
REQ-038 Async reset mid-stream: back-to-back writes to r1..r4, then reset pulsed between edges -> r1..r4 read 0 immediately, w_wb_valid drops immediately, and the write presented in the reset cycle is not stored.

Source files
------------

// File: rtl/reg_file_wb.sv
// 32x32 register file: two combinational read ports with write-through bypass,
// one write port, and a registered write-back log of the last committed write.
module reg_file_wb (
  input  logic        clock,
  input  logic        reset,
  input  logic        w_en,
  input  logic        w_waddr_sel,
  input  logic [4:0]  w_rt,
  input  logic [4:0]  w_rd,
  input  logic [31:0] w_wdata,
  input  logic [4:0]  w_raddr_a,
  input  logic [4:0]  w_raddr_b,
  output logic [31:0] w_rdata_a,
  output logic [31:0] w_rdata_b,
  output logic        w_wb_valid,
  output logic [4:0]  w_wb_addr,
  output logic [31:0] w_wb_data
);

  logic [31:0] regs [0:31];
  logic [4:0]  eff_addr;
  logic        commit;

  // Write handshake: there is no ready/backpressure. A write commits on every
  // rising edge where w_en=1, the effective address is nonzero and reset is low.
  // w_en=0 is dominant, so X/Z on the other write inputs cannot leak into state.
  assign eff_addr = w_waddr_sel ? w_rt : w_rd;
  assign commit   = w_en & (eff_addr != 5'd0) & ~reset;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 32'h0;
      end
    end else if (commit) begin
      regs[eff_addr] <= w_wdata;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      w_wb_valid <= 1'b0;
      w_wb_addr  <= 5'd0;
      w_wb_data  <= 32'h0;
    end else begin
      w_wb_valid <= commit;
      if (commit) begin
        w_wb_addr <= eff_addr;
        w_wb_data <= w_wdata;
      end
    end
  end

  // The bypass keys off commit, so it is off during reset and for address 0.
  always_comb begin
    w_rdata_a = 32'h0;
    w_rdata_b = 32'h0;
    if (commit && (eff_addr == w_raddr_a)) begin
      w_rdata_a = w_wdata;
    end else if (w_raddr_a != 5'd0) begin
      w_rdata_a = regs[w_raddr_a];
    end
    if (commit && (eff_addr == w_raddr_b)) begin
      w_rdata_b = w_wdata;
    end else if (w_raddr_b != 5'd0) begin
      w_rdata_b = regs[w_raddr_b];
    end
  end

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed, table-driven bench for reg_file_wb with hand-written sequences for
// reset behaviour and mid-cycle asynchronous reset.
module tb_reg_file_wb;

  logic        clock;
  logic        reset;
  logic        w_en;
  logic        w_waddr_sel;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [31:0] w_wdata;
  logic [4:0]  w_raddr_a;
  logic [4:0]  w_raddr_b;
  logic [31:0] w_rdata_a;
  logic [31:0] w_rdata_b;
  logic        w_wb_valid;
  logic [4:0]  w_wb_addr;
  logic [31:0] w_wb_data;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        en;
    logic        sel;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic        exp_valid;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  reg_file_wb dut (
    .clock       (clock),
    .reset       (reset),
    .w_en        (w_en),
    .w_waddr_sel (w_waddr_sel),
    .w_rt        (w_rt),
    .w_rd        (w_rd),
    .w_wdata     (w_wdata),
    .w_raddr_a   (w_raddr_a),
    .w_raddr_b   (w_raddr_b),
    .w_rdata_a   (w_rdata_a),
    .w_rdata_b   (w_rdata_b),
    .w_wb_valid  (w_wb_valid),
    .w_wb_addr   (w_wb_addr),
    .w_wb_data   (w_wb_data)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic en, input logic sel, input logic [4:0] rt,
                              input logic [4:0] rd, input logic [31:0] wdata,
                              input logic [4:0] ra, input logic [4:0] rb,
                              input logic [31:0] exp_a, input logic [31:0] exp_b,
                              input logic exp_valid, input logic [4:0] exp_addr,
                              input logic [31:0] exp_data);
    vec_t v;
    v.en = en; v.sel = sel; v.rt = rt; v.rd = rd; v.wdata = wdata;
    v.ra = ra; v.rb = rb; v.exp_a = exp_a; v.exp_b = exp_b;
    v.exp_valid = exp_valid; v.exp_addr = exp_addr; v.exp_data = exp_data;
    return v;
  endfunction

  // driver: present inputs at negedge, check reads before the edge, log after it
  task automatic apply(input vec_t v, input int idx);
    @(negedge clock);
    w_en = v.en; w_waddr_sel = v.sel; w_rt = v.rt; w_rd = v.rd; w_wdata = v.wdata;
    w_raddr_a = v.ra; w_raddr_b = v.rb;
    #1;
    check($sformatf("vec%0d rdata_a", idx), w_rdata_a, v.exp_a);
    check($sformatf("vec%0d rdata_b", idx), w_rdata_b, v.exp_b);
    if (v.exp_valid) exp_q.push_back(v.exp_data);
    @(posedge clock);
    #1;
    check($sformatf("vec%0d wb_valid", idx), {31'd0, w_wb_valid}, {31'd0, v.exp_valid});
    check($sformatf("vec%0d wb_addr", idx), {27'd0, w_wb_addr}, {27'd0, v.exp_addr});
    check($sformatf("vec%0d wb_data", idx), w_wb_data, v.exp_data);
    if (w_wb_valid) begin
      if (exp_q.size() == 0) begin
        check($sformatf("vec%0d sb_unexpected", idx), 32'd1, 32'd0);
      end else begin
        check($sformatf("vec%0d sb_data", idx), w_wb_data, exp_q.pop_front());
      end
    end
  endtask

  initial begin
    // reset asserted with a matching write presented: bypass must be off
    reset = 1'b1;
    w_en = 1'b1; w_waddr_sel = 1'b0; w_rt = 5'd0; w_rd = 5'd5; w_wdata = 32'hFFFFFFFF;
    w_raddr_a = 5'd5; w_raddr_b = 5'd5;
    #2;
    check("rst rdata_a", w_rdata_a, 32'h0);
    check("rst rdata_b", w_rdata_b, 32'h0);
    check("rst wb_valid", {31'd0, w_wb_valid}, 32'd0);
    repeat (2) @(posedge clock);
    #1;
    check("rst hold rdata_a", w_rdata_a, 32'h0);
    check("rst hold wb_valid", {31'd0, w_wb_valid}, 32'd0);
    check("rst hold wb_addr", {27'd0, w_wb_addr}, 32'd0);
    check("rst hold wb_data", w_wb_data, 32'h0);
    @(negedge clock);
    w_en = 1'b0;
    reset = 1'b0;

    // every address reads zero on both ports after reset
    for (int i = 0; i < 32; i++) begin
      @(negedge clock);
      w_raddr_a = 5'(i);
      w_raddr_b = 5'(31 - i);
      #1;
      check($sformatf("post_rst a[%0d]", i), w_rdata_a, 32'h0);
      check($sformatf("post_rst b[%0d]", 31 - i), w_rdata_b, 32'h0);
      check($sformatf("post_rst valid[%0d]", i), {31'd0, w_wb_valid}, 32'd0);
    end

    //                en    sel   rt     rd     wdata          ra     rb     exp_a          exp_b          v     addr   data
    vecs.push_back(mk(1'b1, 1'b1, 5'd5,  5'd9,  32'hDEADBEEF, 5'd5,  5'd9,  32'hDEADBEEF, 32'h0,        1'b1, 5'd5,  32'hDEADBEEF));
    vecs.push_back(mk(1'b0, 1'b0, 5'd0,  5'd0,  32'h0,        5'd5,  5'd9,  32'hDEADBEEF, 32'h0,        1'b0, 5'd5,  32'hDEADBEEF));
    vecs.push_back(mk(1'b1, 1'b0, 5'd5,  5'd9,  32'h12345678, 5'd5,  5'd9,  32'hDEADBEEF, 32'h12345678, 1'b1, 5'd9,  32'h12345678));
    vecs.push_back(mk(1'b0, 1'b0, 5'd0,  5'd0,  32'h0,        5'd9,  5'd5,  32'h12345678, 32'hDEADBEEF, 1'b0, 5'd9,  32'h12345678));
    vecs.push_back(mk(1'b1, 1'b0, 5'd0,  5'd7,  32'hA5A5A5A5, 5'd7,  5'd7,  32'hA5A5A5A5, 32'hA5A5A5A5, 1'b1, 5'd7,  32'hA5A5A5A5));
    vecs.push_back(mk(1'b0, 1'b0, 5'd0,  5'd0,  32'h0,        5'd7,  5'd0,  32'hA5A5A5A5, 32'h0,        1'b0, 5'd7,  32'hA5A5A5A5));
    vecs.push_back(mk(1'b1, 1'b0, 5'd3,  5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 5'd7,  32'hA5A5A5A5));
    vecs.push_back(mk(1'b1, 1'b1, 5'd0,  5'd7,  32'hFFFFFFFF, 5'd0,  5'd7,  32'h0,        32'hA5A5A5A5, 1'b0, 5'd7,  32'hA5A5A5A5));
    vecs.push_back(mk(1'b1, 1'b1, 5'd10, 5'd0,  32'h0000000A, 5'd10, 5'd5,  32'h0000000A, 32'hDEADBEEF, 1'b1, 5'd10, 32'h0000000A));
    vecs.push_back(mk(1'b1, 1'b0, 5'd0,  5'd11, 32'h0000000B, 5'd10, 5'd11, 32'h0000000A, 32'h0000000B, 1'b1, 5'd11, 32'h0000000B));
    vecs.push_back(mk(1'b0, 1'b0, 5'd0,  5'd0,  32'h0,        5'd11, 5'd10, 32'h0000000B, 32'h0000000A, 1'b0, 5'd11, 32'h0000000B));
    vecs.push_back(mk(1'b0, 1'bx, 5'd3,  5'd3,  32'h00000001, 5'd3,  5'd3,  32'h0,        32'h0,        1'b0, 5'd11, 32'h0000000B));
    vecs.push_back(mk(1'b0, 1'bx, 5'd3,  5'd3,  32'h00000001, 5'd3,  5'd3,  32'h0,        32'h0,        1'b0, 5'd11, 32'h0000000B));
    vecs.push_back(mk(1'b0, 1'bx, 5'd3,  5'd3,  32'h00000001, 5'd3,  5'd3,  32'h0,        32'h0,        1'b0, 5'd11, 32'h0000000B));
    vecs.push_back(mk(1'b0, 1'b0, 5'd0,  5'd0,  32'h0,        5'd3,  5'd0,  32'h0,        32'h0,        1'b0, 5'd11, 32'h0000000B));

    foreach (vecs[i]) apply(vecs[i], i);

    // back-to-back writes to r1..r4; port A reads the previously written register
    for (int i = 1; i <= 4; i++) begin
      vec_t v;
      v = mk(1'b1, 1'b0, 5'd0, 5'(i), 32'h100 + 32'(i), 5'(i - 1), 5'(i),
             (i == 1) ? 32'h0 : 32'h100 + 32'(i - 1), 32'h100 + 32'(i),
             1'b1, 5'(i), 32'h100 + 32'(i));
      apply(v, 100 + i);
    end

    // reset pulsed between edges while a write to r5 is pending
    @(negedge clock);
    w_en = 1'b1; w_waddr_sel = 1'b0; w_rd = 5'd5; w_wdata = 32'h00000055;
    w_raddr_a = 5'd1; w_raddr_b = 5'd2;
    #1;
    check("pre_rst r1", w_rdata_a, 32'h101);
    check("pre_rst r2", w_rdata_b, 32'h102);
    check("pre_rst wb_valid", {31'd0, w_wb_valid}, 32'd1);
    exp_q.delete();
    reset = 1'b1;
    #1;
    check("mid_rst r1", w_rdata_a, 32'h0);
    check("mid_rst r2", w_rdata_b, 32'h0);
    check("mid_rst wb_valid", {31'd0, w_wb_valid}, 32'd0);
    check("mid_rst wb_addr", {27'd0, w_wb_addr}, 32'd0);
    check("mid_rst wb_data", w_wb_data, 32'h0);
    w_raddr_a = 5'd3; w_raddr_b = 5'd4;
    #1;
    check("mid_rst r3", w_rdata_a, 32'h0);
    check("mid_rst r4", w_rdata_b, 32'h0);
    w_raddr_a = 5'd5; w_raddr_b = 5'd5;
    #1;
    check("mid_rst bypass_a", w_rdata_a, 32'h0);
    check("mid_rst bypass_b", w_rdata_b, 32'h0);
    w_en = 1'b0;
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("post_pulse r5", w_rdata_a, 32'h0);
    check("post_pulse wb_valid", {31'd0, w_wb_valid}, 32'd0);

    // writes resume on the first edge after reset
    apply(mk(1'b1, 1'b1, 5'd6, 5'd0, 32'hCAFEF00D, 5'd6, 5'd4,
             32'hCAFEF00D, 32'h0, 1'b1, 5'd6, 32'hCAFEF00D), 200);
    apply(mk(1'b0, 1'b0, 5'd0, 5'd0, 32'h0, 5'd6, 5'd1,
             32'hCAFEF00D, 32'h0, 1'b0, 5'd6, 32'hCAFEF00D), 201);

    check("exp_q drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
